// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard between ID and EX: tracks fixed-latency forward countdowns
// and variable-latency (long) pending writes, and raises the ID-stage stall with its reasons.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5,
    parameter int LAT_W    = 3,
    parameter int MAX_LONG = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IDX_W-1:0]              id_rs1,
    input  logic [IDX_W-1:0]              id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [IDX_W-1:0]              id_rd,
    input  logic                          id_rd_wen,
    input  logic                          id_is_long,
    input  logic                          iss_valid,
    input  logic [IDX_W-1:0]              iss_rd,
    input  logic                          iss_wen,
    input  logic [LAT_W-1:0]              iss_lat,
    input  logic                          iss_long,
    input  logic                          wb_valid,
    input  logic [IDX_W-1:0]              wb_rd,
    input  logic                          kill_all,
    output logic                          stall,
    output logic                          stall_raw,
    output logic                          stall_waw,
    output logic                          stall_full,
    output logic [$clog2(MAX_LONG+1)-1:0] long_cnt
);
    localparam int CNT_W = $clog2(MAX_LONG + 1);
    localparam logic [CNT_W-1:0] LONG_FULL = CNT_W'(MAX_LONG);

    logic [LAT_W-1:0]    cnt_reg  [NUM_REGS];
    logic [LAT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] long_reg;
    logic [NUM_REGS-1:0] long_next;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    long_cnt_reg;
    logic [CNT_W-1:0]    long_cnt_next;

    logic iss_ok;
    logic wb_free;
    logic cnt_inc;
    logic cnt_dec;

    // A kill discards the issuing instruction entirely; only the countdowns keep running.
    assign iss_ok  = iss_valid & iss_wen & (iss_rd != '0) & ~kill_all;
    assign wb_free = wb_valid & (wb_rd != '0) & long_reg[wb_rd];
    assign cnt_inc = iss_ok & iss_long;
    assign cnt_dec = wb_free & ~kill_all;

    // x0 never holds a hazard.
    assign cnt_next[0]  = '0;
    assign long_next[0] = 1'b0;
    assign busy[0]      = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic sel_iss;
            logic sel_wb;

            assign sel_iss = iss_ok & (iss_rd == IDX_W'(gi));
            assign sel_wb  = wb_free & (wb_rd == IDX_W'(gi));

            // A new issue replaces whatever countdown was running (in-order WAW).
            assign cnt_next[gi] = sel_iss ? (iss_long ? '0 : iss_lat)
                                : (cnt_reg[gi] != '0) ? cnt_reg[gi] - LAT_W'(1)
                                : cnt_reg[gi];

            // Issue-long beats a same-cycle writeback to the same register.
            assign long_next[gi] = kill_all           ? 1'b0
                                 : (sel_iss & iss_long) ? 1'b1
                                 : sel_wb             ? 1'b0
                                 : long_reg[gi];

            assign busy[gi] = (cnt_reg[gi] != '0) | long_reg[gi];
        end
    endgenerate

    assign long_cnt_next = kill_all ? '0
                         : long_cnt_reg + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            long_reg     <= '0;
            long_cnt_reg <= '0;
        end else begin
            long_reg     <= long_next;
            long_cnt_reg <= long_cnt_next;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_reg[i] <= rst ? '0 : cnt_next[i];
        end
    end

    always_comb begin
        stall_raw  = 1'b0;
        stall_waw  = 1'b0;
        stall_full = 1'b0;
        if (!rst) begin
            stall_raw  = (id_rs1_used & (id_rs1 != '0) & busy[id_rs1])
                       | (id_rs2_used & (id_rs2 != '0) & busy[id_rs2]);
            stall_waw  = id_rd_wen & (id_rd != '0) & long_reg[id_rd];
            // A writeback in the same cycle frees a slot for the waiting long op.
            stall_full = id_is_long & (long_cnt_reg == LONG_FULL) & ~wb_free;
        end
    end

    assign stall    = stall_raw | stall_waw | stall_full;
    assign long_cnt = long_cnt_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against an array-based model of the scoreboard rules.
module tb_hazard_scoreboard;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int LAT_W    = 3;
    localparam int MAX_LONG = 4;
    localparam int CNT_W    = $clog2(MAX_LONG + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [IDX_W-1:0] id_rs1, id_rs2, id_rd, iss_rd, wb_rd;
    logic             id_rs1_used, id_rs2_used, id_rd_wen, id_is_long;
    logic             iss_valid, iss_wen, iss_long, wb_valid, kill_all;
    logic [LAT_W-1:0] iss_lat;
    logic             stall, stall_raw, stall_waw, stall_full;
    logic [CNT_W-1:0] long_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .LAT_W(LAT_W), .MAX_LONG(MAX_LONG)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_long(id_is_long),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_lat(iss_lat),
        .iss_long(iss_long), .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_all(kill_all),
        .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_full(stall_full),
        .long_cnt(long_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: remaining forward-ready cycles, pending-long flag, long op count.
    int m_cnt  [NUM_REGS];
    bit m_long [NUM_REGS];
    int m_lc;
    bit model_ok = 1'b0;
    bit m_wbh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && ((m_cnt[r] != 0) || m_long[r]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_cnt[r]  = 0;
                m_long[r] = 1'b0;
            end
            m_lc     = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_wbh = wb_valid && (wb_rd != 0) && m_long[wb_rd];
            for (int r = 0; r < NUM_REGS; r++) begin
                if (m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
            end
            if (kill_all) begin
                for (int r = 0; r < NUM_REGS; r++) m_long[r] = 1'b0;
                m_lc = 0;
            end else begin
                if (m_wbh) begin
                    m_long[wb_rd] = 1'b0;
                    m_lc = m_lc - 1;
                end
                if (iss_valid && iss_wen && (iss_rd != 0)) begin
                    if (iss_long) begin
                        m_long[iss_rd] = 1'b1;
                        m_cnt[iss_rd]  = 0;
                        m_lc = m_lc + 1;
                    end else begin
                        m_cnt[iss_rd] = int'(iss_lat);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_raw, e_waw, e_full;
        if (model_ok) begin
            e_raw  = 1'b0;
            e_waw  = 1'b0;
            e_full = 1'b0;
            if (!rst) begin
                e_raw  = (id_rs1_used && m_busy(int'(id_rs1))) || (id_rs2_used && m_busy(int'(id_rs2)));
                e_waw  = id_rd_wen && (id_rd != 0) && m_long[id_rd];
                e_full = id_is_long && (m_lc == MAX_LONG)
                         && !(wb_valid && (wb_rd != 0) && m_long[wb_rd]);
            end
            chk("stall_raw", int'(stall_raw), int'(e_raw));
            chk("stall_waw", int'(stall_waw), int'(e_waw));
            chk("stall_full", int'(stall_full), int'(e_full));
            chk("stall", int'(stall), int'(e_raw | e_waw | e_full));
            chk("long_cnt", int'(long_cnt), m_lc);
            chk("long_cnt_bound", int'(int'(long_cnt) <= MAX_LONG), 1);
        end
    end

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = '0; id_rd_wen = 1'b0; id_is_long = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; iss_wen = 1'b0; iss_lat = '0; iss_long = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; kill_all = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int lat, input bit lng);
        iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = IDX_W'(rd);
        iss_lat = LAT_W'(lat); iss_long = lng;
    endtask

    int  rr;
    bit  rlng, rwen, prev_stall;

    initial begin
        idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset state
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);
        chk("reset_long_cnt", int'(long_cnt), 0);
        next_cycle();

        // 1: load-use gives exactly one stall cycle
        idle(); issue(5, 1, 1'b0);
        next_cycle();
        idle(); id_rs1 = 5'd5; id_rs1_used = 1'b1;
        @(negedge clk);
        chk("t1_stall", int'(stall), 1);
        chk("t1_raw", int'(stall_raw), 1);
        next_cycle();
        @(negedge clk);
        chk("t1_clear", int'(stall), 0);
        next_cycle();

        // 2a: MUL latency 3 stalls three cycles
        idle(); issue(7, 3, 1'b0);
        next_cycle();
        for (int i = 1; i <= 3; i++) begin
            idle(); id_rs2 = 5'd7; id_rs2_used = 1'b1;
            @(negedge clk);
            chk("t2_mul_stall", int'(stall), 1);
            next_cycle();
        end
        @(negedge clk);
        chk("t2_mul_clear", int'(stall), 0);
        next_cycle();

        // 2b: a younger lat=1 write overrides the older countdown
        idle(); issue(7, 3, 1'b0);
        next_cycle();
        idle(); issue(7, 1, 1'b0);
        next_cycle();
        idle(); id_rs2 = 5'd7; id_rs2_used = 1'b1;
        @(negedge clk);
        chk("t2_reissue_stall", int'(stall), 1);
        next_cycle();
        @(negedge clk);
        chk("t2_reissue_clear", int'(stall), 0);
        next_cycle();

        // 3: long op holds RAW until the cycle after writeback
        idle(); issue(9, 0, 1'b1);
        next_cycle();
        for (int i = 1; i <= 9; i++) begin
            idle(); id_rs1 = 5'd9; id_rs1_used = 1'b1;
            @(negedge clk);
            chk("t3_hold", int'(stall), 1);
            next_cycle();
        end
        idle(); id_rs1 = 5'd9; id_rs1_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd9;
        @(negedge clk);
        chk("t3_wb_cycle_stall", int'(stall), 1);
        chk("t3_cnt_before", int'(long_cnt), 1);
        next_cycle();
        idle(); id_rs1 = 5'd9; id_rs1_used = 1'b1;
        @(negedge clk);
        chk("t3_clear", int'(stall), 0);
        chk("t3_cnt_after", int'(long_cnt), 0);
        next_cycle();

        // 4: long table full, same-cycle wb frees a slot
        for (int r = 1; r <= 4; r++) begin
            idle(); issue(r, 0, 1'b1);
            next_cycle();
        end
        idle(); id_is_long = 1'b1; id_rd = 5'd5; id_rd_wen = 1'b1;
        @(negedge clk);
        chk("t4_full", int'(stall_full), 1);
        chk("t4_cnt_full", int'(long_cnt), 4);
        next_cycle();
        idle(); id_is_long = 1'b1; id_rd = 5'd5; id_rd_wen = 1'b1; wb_valid = 1'b1; wb_rd = 5'd2;
        @(negedge clk);
        chk("t4_full_freed", int'(stall_full), 0);
        chk("t4_stall_freed", int'(stall), 0);
        next_cycle();
        idle(); issue(5, 0, 1'b1);
        @(negedge clk);
        chk("t4_cnt_mid", int'(long_cnt), 3);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t4_cnt_refill", int'(long_cnt), 4);
        next_cycle();

        // 5: WAW on pending long rd, then kill_all clears everything
        idle(); id_rd = 5'd3; id_rd_wen = 1'b1;
        @(negedge clk);
        chk("t5_waw", int'(stall_waw), 1);
        chk("t5_stall", int'(stall), 1);
        next_cycle();
        idle(); kill_all = 1'b1;
        next_cycle();
        idle(); id_rd = 5'd3; id_rd_wen = 1'b1; id_is_long = 1'b1;
        @(negedge clk);
        chk("t5_cnt_killed", int'(long_cnt), 0);
        chk("t5_stall_killed", int'(stall), 0);
        next_cycle();

        // 6: x0 never tracked; reset mid long op
        idle(); id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_wen = 1'b1;
        issue(0, 0, 1'b1);
        @(negedge clk);
        chk("t6_x0_stall", int'(stall), 0);
        next_cycle();
        idle(); id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_wen = 1'b1;
        issue(0, 5, 1'b0);
        @(negedge clk);
        chk("t6_x0_cnt", int'(long_cnt), 0);
        chk("t6_x0_stall2", int'(stall), 0);
        next_cycle();
        idle(); issue(6, 0, 1'b1);
        next_cycle();
        idle(); id_rs1 = 5'd6; id_rs1_used = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_stall", int'(stall), 0);
        chk("t6_rst_raw", int'(stall_raw), 0);
        chk("t6_rst_cnt_pre", int'(long_cnt), 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_cnt", int'(long_cnt), 0);
        chk("t6_rst_clear", int'(stall), 0);
        next_cycle();

        // Randomized traffic, constrained to what a well-behaved pipeline would issue
        prev_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst      = ($urandom_range(0, 299) == 0);
            kill_all = ($urandom_range(0, 59) == 0);
            id_rs1      = IDX_W'($urandom_range(0, 7));
            id_rs2      = IDX_W'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = IDX_W'($urandom_range(0, 7));
            id_rd_wen   = 1'($urandom_range(0, 1));
            id_is_long  = ($urandom_range(0, 2) == 0);
            if (!prev_stall && ($urandom_range(0, 3) != 0)) begin
                rr   = $urandom_range(0, 7);
                rlng = ($urandom_range(0, 3) == 0);
                rwen = ($urandom_range(0, 4) != 0);
                if (!(rwen && rr != 0 && m_long[rr]) && !(rlng && rwen && rr != 0 && m_lc >= MAX_LONG)) begin
                    issue(rr, $urandom_range(0, 7), rlng);
                    iss_wen = rwen;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                wb_rd    = IDX_W'($urandom_range(0, 7));
            end
            @(negedge clk);
            prev_stall = stall;
            next_cycle();
        end

        idle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single load-use stall detector.
- Sits between ID and EX. Tracks every in-flight register write in a per-register scoreboard.
- Producers are either fixed-latency (ALU, load, multi-cycle MUL) or variable-latency (DIV, uncached load). Variable-latency producers complete through a writeback port.
- Drives the ID-stage stall for RAW hazards, long-op WAW hazards and scoreboard-capacity hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- IDX_W, 5, register index width (clog2 NUM_REGS).
- LAT_W, 3, width of the per-register forward-ready countdown; max fixed latency is 2^LAT_W-1.
- MAX_LONG, 4, max simultaneous variable-latency ops in flight.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  IDX_W  ID-stage source 1 index
- id_rs2  in  IDX_W  ID-stage source 2 index
- id_rs1_used  in  1  rs1 actually read
- id_rs2_used  in  1  rs2 actually read
- id_rd  in  IDX_W  ID-stage destination
- id_rd_wen  in  1  ID instr writes rd
- id_is_long  in  1  ID instr is variable-latency
- iss_valid  in  1  instr entering EX this cycle (0 for bubbles)
- iss_rd  in  IDX_W  issuing destination
- iss_wen  in  1  issuing instr writes rd
- iss_lat  in  LAT_W  cycles until result is forwardable; 0 = next cycle (ALU), 1 = load
- iss_long  in  1  issuing instr is variable-latency; iss_lat ignored
- wb_valid  in  1  variable-latency result written back
- wb_rd  in  IDX_W  its destination
- kill_all  in  1  trap/pipeline kill: drop all long entries
- stall  out  1  hold ID/IF, insert bubble into EX
- stall_raw  out  1  reason: source operand not ready
- stall_waw  out  1  reason: rd has pending long write
- stall_full  out  1  reason: long table full
- long_cnt  out  clog2(MAX_LONG+1)  long ops in flight

Behaviour:
- State per reg r (1..NUM_REGS-1): cnt[r] (LAT_W), long[r] (1). long_cnt is a registered count.
- Reset (rst=1 at posedge): all cnt=0, long=0, long_cnt=0. While rst=1, stall and all reason outputs are forced to 0.
- Each cycle, every cnt[r]!=0 decrements by 1. This happens before the issue update is applied.
- Issue update (iss_valid & iss_wen & iss_rd!=0):
  - iss_long=0, iss_lat>0: cnt[iss_rd] <= iss_lat. This overrides the decrement and any prior value (in-order WAW).
  - iss_long=0, iss_lat=0: no entry; cnt[iss_rd] <= 0.
  - iss_long=1: long[iss_rd] <= 1, cnt[iss_rd] <= 0, long_cnt +1.
- Writeback: wb_valid & wb_rd!=0 & long[wb_rd]: long[wb_rd] <= 0, long_cnt -1.
  - wb_valid to a non-long register is ignored; long_cnt is unchanged.
- Same cycle, issue-long and wb to the same rd: issue wins. long stays 1 and long_cnt is unchanged (+1 -1).
- kill_all: all long <= 0, long_cnt <= 0. Same-cycle issue and wb are ignored. cnt entries keep decrementing.
- A register is busy when cnt!=0 or long=1. State is visible the cycle after the update. A load issued at cycle t therefore stalls a dependent in ID at t+1 only, giving one bubble and matching the legacy load-use behaviour.
- Stall conditions (combinational from registered state and id_* inputs):
  - stall_raw = (rs1_used & rs1!=0 & busy[rs1]) | (rs2_used & rs2!=0 & busy[rs2])
  - stall_waw = id_rd_wen & id_rd!=0 & long[id_rd]
  - stall_full = id_is_long & long_cnt==MAX_LONG & ~(wb_valid & long[wb_rd] & wb_rd!=0). Same-cycle wb frees a slot.
  - stall = OR of the three reasons.
- A RAW dependence on a long reg clears the cycle after wb. No same-cycle wb bypass is provided for RAW.
- The bench asserts that long_cnt never exceeds MAX_LONG.
- The pipeline guarantees iss_valid=0 in the cycle after stall=1.

Test Plan:
1. Reset, then iss load rd=5, lat=1 at t; ID rs1=5 at t+1 -> stall=1, stall_raw=1 at t+1; stall=0 at t+2.
2. iss MUL rd=7, lat=3 at t; ID rs2=7 -> stall at t+1..t+3, clear at t+4. Then reissue rd=7 lat=1 at t+1 -> stall only at t+2.
3. iss long rd=9; ID reads rs1=9 for 10 cycles -> stall held; wb_valid rd=9 at t+10 -> stall=0 at t+11, long_cnt 1->0.
4. Issue 4 long ops to rd 1..4; ID id_is_long=1 -> stall_full=1. Same cycle wb rd=2 -> stall_full=0; long_cnt stays 4 after new issue.
5. long pending rd=3; ID id_rd=3, id_rd_wen=1 -> stall_waw=1. Then kill_all -> long_cnt=0, stall=0 next cycle.
6. ID rs1=0, rs2=0, rd=0 with any state; iss to rd=0 -> no stall, no entry; rst asserted mid-long-op -> all outputs 0, long_cnt=0.
